// File: rtl/rpn_key_arbiter.sv
// Round-robin arbiter and sequencer in front of the RPN stack key port.
// Each key is issued as a one-cycle intro pulse, followed by a cooldown while the stack works.
module rpn_key_arbiter #(
  parameter int unsigned GAP_KEY = 4,
  parameter int unsigned GAP_OP  = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [4:0] a_code,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [4:0] b_code,
  output logic       b_ready,
  output logic [4:0] in_num,
  output logic       intro,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam logic [7:0] GapKey  = 8'(GAP_KEY);
  localparam logic [7:0] GapOp   = 8'(GAP_OP);
  localparam logic [4:0] CodeNop = 5'h16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCool
  } state_e;

  state_e     state_q, state_d;
  logic       pri_q, pri_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] in_num_q, in_num_d;
  logic       intro_q, intro_d;
  logic [7:0] drop_q, drop_d;

  logic       arb_en;
  logic       pick_a, pick_b;
  logic       grant_a, grant_b;
  logic [4:0] win_code;
  logic       win_ok;

  function automatic logic code_ok(input logic [4:0] code);
    return (code <= 5'h09) || ((code >= 5'h10) && (code <= 5'h16));
  endfunction

  function automatic logic code_is_op(input logic [4:0] code);
    return (code == 5'h10) || (code == 5'h11);
  endfunction

  // Arbitration runs in IDLE and in the final COOL cycle, so the next key
  // is accepted on the last cooldown edge and back-to-back spacing is 1+GAP.
  always_comb begin
    arb_en   = (state_q == StIdle) || ((state_q == StCool) && (cnt_q == 8'd1));
    pick_a   = a_valid && (!b_valid || !pri_q);
    pick_b   = b_valid && (!a_valid || pri_q);
    grant_a  = rst_n && arb_en && pick_a;
    grant_b  = rst_n && arb_en && pick_b;
    win_code = grant_b ? b_code : a_code;
    win_ok   = code_ok(win_code);
  end

  always_comb begin
    state_d  = state_q;
    pri_d    = pri_q;
    cnt_d    = cnt_q;
    in_num_d = in_num_q;
    intro_d  = 1'b0;
    drop_d   = drop_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
      end
      StIssue: begin
        cnt_d   = code_is_op(in_num_q) ? GapOp : GapKey;
        state_d = StCool;
      end
      StCool: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase

    if (grant_a || grant_b) begin
      // Priority passes to the side that lost (or did not compete) this round.
      pri_d = grant_a;
      if (win_ok) begin
        in_num_d = win_code;
        intro_d  = 1'b1;
        state_d  = StIssue;
        cnt_d    = 8'd0;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pri_q    <= 1'b0;
      cnt_q    <= 8'd0;
      in_num_q <= CodeNop;
      intro_q  <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      pri_q    <= pri_d;
      cnt_q    <= cnt_d;
      in_num_q <= in_num_d;
      intro_q  <= intro_d;
      drop_q   <= drop_d;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign in_num   = in_num_q;
  assign intro    = intro_q;
  assign busy     = (state_q != StIdle);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_rpn_key_arbiter.sv
// Self-checking bench for rpn_key_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-count reference model.
module tb_rpn_key_arbiter;

  localparam int unsigned KGap = 4;
  localparam int unsigned OGap = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [4:0] a_code = 5'h00;
  logic       b_valid = 1'b0;
  logic [4:0] b_code = 5'h00;
  logic       a_ready, b_ready, intro, busy;
  logic [4:0] in_num;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  rpn_key_arbiter #(
    .GAP_KEY(KGap),
    .GAP_OP (OGap)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_code  (a_code),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_code  (b_code),
    .b_ready (b_ready),
    .in_num  (in_num),
    .intro   (intro),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [4:0] ac;
    logic       bv;
    logic [4:0] bc;
    logic       ar;
    logic       br;
    logic       intro;
    logic [4:0] num;
    logic       busy;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic av, input logic [4:0] ac, input logic bv,
                              input logic [4:0] bc, input logic ar, input logic br,
                              input logic it, input logic [4:0] num, input logic bz);
    vec_t v;
    v.av = av; v.ac = ac; v.bv = bv; v.bc = bc;
    v.ar = ar; v.br = br; v.intro = it; v.num = num; v.busy = bz;
    return v;
  endfunction

  function automatic bit is_valid_code(input logic [4:0] c);
    return (c <= 5'h09) || (c >= 5'h10 && c <= 5'h16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // ---------------- reset behaviour ----------------
    a_valid = 1'b1; a_code = 5'h07;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_in_num", in_num, 5'h16);
    chk("rst_intro", intro, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_a_ready", a_ready, 1);
    go();
    a_valid = 1'b0;
    @(negedge clk);
    chk("rel_intro", intro, 1);
    chk("rel_in_num", in_num, 5'h07);

    // ---------------- round-robin vector table ----------------
    for (int i = 0; i < 22; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 5'h06, 1);
    tbl[0]  = mk(1, 3, 1, 5, 1, 0, 0, 5'h16, 0);
    tbl[1]  = mk(1, 4, 1, 5, 0, 0, 1, 5'h03, 1);
    for (int i = 2; i < 5; i++) tbl[i] = mk(1, 4, 1, 5, 0, 0, 0, 5'h03, 1);
    tbl[5]  = mk(1, 4, 1, 5, 0, 1, 0, 5'h03, 1);
    tbl[6]  = mk(1, 4, 1, 6, 0, 0, 1, 5'h05, 1);
    for (int i = 7; i < 10; i++) tbl[i] = mk(1, 4, 1, 6, 0, 0, 0, 5'h05, 1);
    tbl[10] = mk(1, 4, 1, 6, 1, 0, 0, 5'h05, 1);
    tbl[11] = mk(0, 0, 1, 6, 0, 0, 1, 5'h04, 1);
    for (int i = 12; i < 15; i++) tbl[i] = mk(0, 0, 1, 6, 0, 0, 0, 5'h04, 1);
    tbl[15] = mk(0, 0, 1, 6, 0, 1, 0, 5'h04, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 5'h06, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 5'h06, 0);

    a_valid = tbl[0].av; a_code = tbl[0].ac; b_valid = tbl[0].bv; b_code = tbl[0].bc;
    reset_dut();
    for (int i = 0; i < 22; i++) begin
      a_valid = tbl[i].av; a_code = tbl[i].ac; b_valid = tbl[i].bv; b_code = tbl[i].bc;
      @(negedge clk);
      chk($sformatf("rr_a_ready[%0d]", i), a_ready, tbl[i].ar);
      chk($sformatf("rr_b_ready[%0d]", i), b_ready, tbl[i].br);
      chk($sformatf("rr_intro[%0d]", i), intro, tbl[i].intro);
      chk($sformatf("rr_in_num[%0d]", i), in_num, tbl[i].num);
      chk($sformatf("rr_busy[%0d]", i), busy, tbl[i].busy);
      go();
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // ---------------- spacing: 01, PLUS, 02 ----------------
    begin
      logic [4:0] codes[3];
      int         exp_c[3];
      int         pulses[$];
      int         idx;
      logic       got;
      codes[0] = 5'h01; codes[1] = 5'h10; codes[2] = 5'h02;
      exp_c[0] = 1; exp_c[1] = 6; exp_c[2] = 19;
      idx = 0;
      a_valid = 1'b1; a_code = codes[0];
      reset_dut();
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (intro) pulses.push_back(c);
        if (pulses.size() > 0 && pulses.size() <= 3)
          chk($sformatf("sp_in_num[%0d]", c), in_num, codes[pulses.size() - 1]);
        got = a_ready;
        go();
        if (got) begin
          idx++;
          if (idx < 3) a_code = codes[idx];
          else a_valid = 1'b0;
        end
      end
      chk("sp_pulse_count", pulses.size(), 3);
      for (int k = 0; k < 3; k++)
        chk($sformatf("sp_pulse_cycle[%0d]", k), (k < pulses.size()) ? pulses[k] : -1, exp_c[k]);
    end

    // ---------------- invalid codes ----------------
    begin
      logic [4:0] codes[3];
      int         rdy[$];
      int         its[$];
      int         idx;
      logic       got;
      codes[0] = 5'h0C; codes[1] = 5'h1F; codes[2] = 5'h13;
      idx = 0;
      a_valid = 1'b1; a_code = codes[0];
      reset_dut();
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (a_ready) rdy.push_back(c);
        if (intro) begin
          its.push_back(c);
          chk("inv_in_num", in_num, 5'h13);
        end
        if (c == 3) chk("inv_drop", drop_cnt, 2);
        got = a_ready;
        go();
        if (got) begin
          idx++;
          if (idx < 3) a_code = codes[idx];
          else a_valid = 1'b0;
        end
      end
      chk("inv_ready_count", rdy.size(), 3);
      for (int k = 0; k < 3; k++)
        chk($sformatf("inv_ready_cycle[%0d]", k), (k < rdy.size()) ? rdy[k] : -1, k);
      chk("inv_intro_count", its.size(), 1);
      chk("inv_intro_cycle", (its.size() > 0) ? its[0] : -1, 3);
    end

    // ---------------- drop counter saturation ----------------
    a_valid = 1'b1; a_code = 5'h0A;
    reset_dut();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 254) chk("sat_drop_254", drop_cnt, 254);
      if (c == 100) chk("sat_ready", a_ready, 1);
      go();
    end
    @(negedge clk);
    chk("sat_drop_final", drop_cnt, 255);
    chk("sat_intro", intro, 0);
    a_valid = 1'b0;

    // ---------------- async reset during cooldown after PLUS ----------------
    a_valid = 1'b1; a_code = 5'h10; b_valid = 1'b1; b_code = 5'h05;
    reset_dut();
    go();
    a_valid = 1'b0;
    repeat (4) go();
    chk("ar_busy_cool", busy, 1);
    chk("ar_in_num_cool", in_num, 5'h10);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_intro", intro, 0);
    chk("ar_in_num", in_num, 5'h16);
    chk("ar_busy", busy, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_b_ready_low", b_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_b_ready", b_ready, 1);
    chk("ar_in_num_rel", in_num, 5'h16);
    go();
    b_valid = 1'b0;
    @(negedge clk);
    chk("ar_b_intro", intro, 1);
    chk("ar_b_in_num", in_num, 5'h05);

    // ---------------- randomized traffic vs reference model ----------------
    // Model tracks cycle numbers of the last issue and the earliest next arbitration.
    begin
      int         last_acc, last_gap, next_arb, m_drop;
      bit         have_acc, m_pri, wa, wb, exp_intro, exp_busy;
      logic [4:0] m_num, code;
      have_acc = 0; last_acc = 0; last_gap = 0; next_arb = 0;
      m_pri = 0; m_num = 5'h16; m_drop = 0;
      a_valid = 1'b0; b_valid = 1'b0;
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
        exp_intro = have_acc && (c == last_acc + 1);
        exp_busy  = have_acc && (c > last_acc) && (c <= last_acc + 1 + last_gap);
        wa = (c >= next_arb) && a_valid && (!b_valid || !m_pri);
        wb = (c >= next_arb) && b_valid && (!a_valid || m_pri);
        @(negedge clk);
        chk("rnd_a_ready", a_ready, wa);
        chk("rnd_b_ready", b_ready, wb);
        chk("rnd_intro", intro, exp_intro);
        chk("rnd_in_num", in_num, m_num);
        chk("rnd_busy", busy, exp_busy);
        chk("rnd_drop", drop_cnt, m_drop);
        @(posedge clk);
        if (wa || wb) begin
          code  = wa ? a_code : b_code;
          m_pri = wa;
          if (is_valid_code(code)) begin
            have_acc = 1;
            last_acc = c;
            last_gap = (code == 5'h10 || code == 5'h11) ? OGap : KGap;
            next_arb = c + 1 + last_gap;
            m_num    = code;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
        #1;
        if (wa) a_valid = 1'b0;
        if (wb) b_valid = 1'b0;
        if (!a_valid && ($urandom_range(0, 2) == 0)) begin
          a_valid = 1'b1;
          a_code  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(16, 22))
                                                : 5'($urandom_range(0, 31));
        end
        if (!b_valid && ($urandom_range(0, 2) == 0)) begin
          b_valid = 1'b1;
          b_code  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 9))
                                                : 5'($urandom_range(0, 31));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
